// File: rtl/pr_cmplt_mc_pkg.sv
// Shared types for the partial-reconfiguration completion tracker.
package lynxTypes;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } pr_cmplt_state_t;

  localparam int unsigned PR_MAX_REGIONS = 16;

endpackage

// File: rtl/pr_cmplt_ch.sv
// One PR region: waits eos_time cycles after the last bitstream beat,
// then pulses eos for one cycle. Tracks overrun (restart while waiting).
module pr_cmplt_ch
  import lynxTypes::*;
#(
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                accept,
  input  logic                abort,
  input  logic [CNT_BITS-1:0] eos_time,
  input  logic                flag_clr,
  output logic                eos,
  output logic                busy,
  output logic                overrun
);

  pr_cmplt_state_t     r_state;
  pr_cmplt_state_t     w_state_nxt;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic [CNT_BITS-1:0] r_tgt;
  logic [CNT_BITS-1:0] w_tgt_nxt;
  logic                r_ovr;
  logic                w_ovr_set;

  // State, counter and target registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  // Next-state logic; abort beats accept, accept (restart) beats cnt==tgt.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    w_ovr_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (accept) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
          w_tgt_nxt   = eos_time;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (accept) begin
          w_cnt_nxt   = '0;
          w_tgt_nxt   = eos_time;
          w_ovr_set   = 1'b1;
        end else if (r_cnt == r_tgt) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (accept) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
          w_tgt_nxt   = eos_time;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Sticky overrun flag; a set in the same cycle as flag_clr wins.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ovr <= 1'b0;
    end else if (w_ovr_set) begin
      r_ovr <= 1'b1;
    end else if (flag_clr) begin
      r_ovr <= 1'b0;
    end
  end

  assign eos     = (r_state == ST_DONE);
  assign busy    = (r_state != ST_IDLE);
  assign overrun = r_ovr;

endmodule

// File: rtl/pr_cmplt_mc.sv
// Multi-region PR completion tracker: decodes pr_id into per-region
// accepts, flags out-of-range ids, and gathers the per-region outputs.
module pr_cmplt_mc
  import lynxTypes::*;
#(
  parameter int unsigned N_REGIONS = 4,
  parameter int unsigned CNT_BITS  = 32,
  parameter int unsigned ID_BITS   = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 pr_val,
  input  logic                 pr_last,
  input  logic [ID_BITS-1:0]   pr_id,
  input  logic [CNT_BITS-1:0]  eos_time,
  input  logic [N_REGIONS-1:0] pr_abort,
  input  logic                 flag_clr,
  output logic [N_REGIONS-1:0] eos,
  output logic [N_REGIONS-1:0] busy,
  output logic [N_REGIONS-1:0] overrun,
  output logic                 id_err
);

  logic                 w_last;
  logic                 w_bad_id;
  logic [N_REGIONS-1:0] w_accept;
  logic                 r_id_err;

  assign w_last   = pr_val & pr_last;
  // Extra MSB keeps the range check meaningful when N_REGIONS is a power of two.
  assign w_bad_id = w_last & ({1'b0, pr_id} >= (ID_BITS+1)'(N_REGIONS));

  for (genvar k = 0; k < N_REGIONS; k++) begin : g_ch
    assign w_accept[k] = w_last & (pr_id == ID_BITS'(k));

    pr_cmplt_ch #(
      .CNT_BITS(CNT_BITS)
    ) u_ch (
      .aclk     (aclk),
      .areset   (areset),
      .accept   (w_accept[k]),
      .abort    (pr_abort[k]),
      .eos_time (eos_time),
      .flag_clr (flag_clr),
      .eos      (eos[k]),
      .busy     (busy[k]),
      .overrun  (overrun[k])
    );
  end

  // Sticky bad-id flag; a set in the same cycle as flag_clr wins.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_id_err <= 1'b0;
    end else if (w_bad_id) begin
      r_id_err <= 1'b1;
    end else if (flag_clr) begin
      r_id_err <= 1'b0;
    end
  end

  assign id_err = r_id_err;

endmodule

// File: tb/tb_pr_cmplt_mc.sv
// Bench for pr_cmplt_mc: a 4-region and a 3-region instance share one
// stimulus stream; each is checked every cycle against a deadline model.
module tb_pr_cmplt_mc;

  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          areset;
  logic          pr_val;
  logic          pr_last;
  logic [1:0]    pr_id;
  logic [CB-1:0] eos_time;
  logic [3:0]    pr_abort;
  logic          flag_clr;

  logic [3:0] eos4, busy4, ovr4;
  logic       iderr4;
  logic [2:0] eos3, busy3, ovr3;
  logic       iderr3;

  always #5 clk = ~clk;

  pr_cmplt_mc #(.N_REGIONS(4), .CNT_BITS(CB)) u_dut4 (
    .aclk(clk), .areset(areset), .pr_val(pr_val), .pr_last(pr_last),
    .pr_id(pr_id), .eos_time(eos_time), .pr_abort(pr_abort),
    .flag_clr(flag_clr), .eos(eos4), .busy(busy4), .overrun(ovr4),
    .id_err(iderr4)
  );

  pr_cmplt_mc #(.N_REGIONS(3), .CNT_BITS(CB)) u_dut3 (
    .aclk(clk), .areset(areset), .pr_val(pr_val), .pr_last(pr_last),
    .pr_id(pr_id), .eos_time(eos_time), .pr_abort(pr_abort[2:0]),
    .flag_clr(flag_clr), .eos(eos3), .busy(busy3), .overrun(ovr3),
    .id_err(iderr3)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference: a region is "active" from the cycle after its accept until
  // its absolute eos deadline (accept cycle + T + 2).
  bit m_act [2][4];
  int m_eoc [2][4];
  bit m_ovr [2][4];
  bit m_iderr [2];
  int nreg [2] = '{4, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    int t;
    bit acc, ovr_set, last;
    t = cyc;
    last = pr_val && pr_last;
    for (int m = 0; m < 2; m++) begin
      if (areset) begin
        for (int k = 0; k < 4; k++) begin
          m_act[m][k] = 0; m_eoc[m][k] = 0; m_ovr[m][k] = 0;
        end
        m_iderr[m] = 0;
      end else begin
        for (int k = 0; k < nreg[m]; k++) begin
          acc = last && (int'(pr_id) == k);
          ovr_set = 0;
          if (m_act[m][k] && pr_abort[k]) begin
            m_act[m][k] = 0;
          end else if (acc) begin
            if (m_act[m][k] && t < m_eoc[m][k]) ovr_set = 1;
            m_act[m][k] = 1;
            m_eoc[m][k] = t + int'(eos_time) + 2;
          end else if (m_act[m][k] && t == m_eoc[m][k]) begin
            m_act[m][k] = 0;
          end
          m_ovr[m][k] = ovr_set | (m_ovr[m][k] & !flag_clr);
        end
        m_iderr[m] = (last && int'(pr_id) >= nreg[m]) | (m_iderr[m] & !flag_clr);
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] ee [2];
    logic [3:0] eb [2];
    logic [3:0] eo [2];
    for (int m = 0; m < 2; m++) begin
      ee[m] = '0; eb[m] = '0; eo[m] = '0;
      for (int k = 0; k < nreg[m]; k++) begin
        eb[m][k] = m_act[m][k];
        ee[m][k] = m_act[m][k] && (cyc == m_eoc[m][k]);
        eo[m][k] = m_ovr[m][k];
      end
    end
    chk("eos4",    32'(eos4),   32'(ee[0]));
    chk("busy4",   32'(busy4),  32'(eb[0]));
    chk("ovr4",    32'(ovr4),   32'(eo[0]));
    chk("iderr4",  32'(iderr4), 32'(m_iderr[0]));
    chk("eos3",    32'(eos3),   32'(ee[1][2:0]));
    chk("busy3",   32'(busy3),  32'(eb[1][2:0]));
    chk("ovr3",    32'(ovr3),   32'(eo[1][2:0]));
    chk("iderr3",  32'(iderr3), 32'(m_iderr[1]));
  endtask

  task automatic drive(input bit v, input bit l, input int id, input int tm,
                       input logic [3:0] ab, input bit clr, input bit rst);
    pr_val   = v;
    pr_last  = l;
    pr_id    = 2'(id);
    eos_time = CB'(tm);
    pr_abort = ab;
    flag_clr = clr;
    areset   = rst;
    @(posedge clk);
    #1;
    model_step();
    cyc++;
    check_outputs();
  endtask

  task automatic last_to(input int id, input int tm);
    drive(1, 1, id, tm, 4'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, int'($urandom_range(0, 255)), 4'b0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 4'b0, 0, 1);
    drive(0, 0, 0, 0, 4'b0, 0, 1);
    idle(3);

    // single completion, region 2, T=10
    last_to(2, 10);
    idle(15);

    // restart while waiting sets overrun; later cleared
    last_to(1, 20);
    idle(4);
    last_to(1, 20);
    idle(25);
    drive(0, 0, 0, 0, 4'b0, 1, 0);
    idle(3);

    // abort mid-wait, then abort coincident with accept
    last_to(0, 50);
    idle(9);
    drive(0, 0, 0, 50, 4'b0001, 0, 0);
    idle(5);
    last_to(0, 50);
    idle(9);
    drive(1, 1, 0, 50, 4'b0001, 0, 0);
    idle(60);

    // T=0 on two regions, then back-to-back accept in the DONE cycle
    last_to(0, 0);
    last_to(3, 0);
    last_to(0, 0);
    idle(6);

    // non-last beats are ignored; id 3 is out of range for the 3-region copy
    drive(1, 0, 1, 4, 4'b0, 0, 0);
    last_to(3, 4);
    idle(8);
    drive(0, 0, 0, 0, 4'b0, 1, 0);
    idle(2);

    // overrun set coincident with flag_clr stays set
    last_to(1, 5);
    idle(1);
    drive(1, 1, 1, 5, 4'b0, 1, 0);
    idle(10);

    // reset mid-wait discards the pending completion
    last_to(2, 30);
    idle(5);
    drive(0, 0, 0, 0, 4'b0, 0, 1);
    idle(40);

    // maximum settle time; counter must stop at tgt without wrapping
    last_to(1, 255);
    idle(262);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0},
            $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
